// File: rtl/types_pkg.sv
// Shared decode packet type plus the functional-unit classification used for steering.
package types_pkg;

    localparam int unsigned PC_W  = 32;
    localparam int unsigned OPC_W = 8;

    // Decoded packet as it leaves decode; fu_* flags name the target issue queue.
    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [OPC_W-1:0] opcode;
        logic             fu_alu;
        logic             fu_mem;
        logic             fu_br;
    } decode_data;

    typedef enum logic [2:0] {
        FU_NONE,
        FU_ALU,
        FU_MEM,
        FU_BR,
        FU_MULTI
    } fu_sel_e;

    // Exactly one flag selects a unit; zero or several flags make the packet malformed.
    function automatic fu_sel_e fu_sel(input decode_data d);
        fu_sel_e sel;
        case ({d.fu_alu, d.fu_mem, d.fu_br})
            3'b000:  sel = FU_NONE;
            3'b100:  sel = FU_ALU;
            3'b010:  sel = FU_MEM;
            3'b001:  sel = FU_BR;
            default: sel = FU_MULTI;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/dispatch_fifo.sv
// In-order packet buffer between decode and dispatch steering.
// Ports: clk/reset, push/pop/flush controls, wdata in, head (entry at rd_ptr),
//        full/empty status.
module dispatch_fifo
    import types_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  decode_data wdata,
    output decode_data head,
    output logic       full,
    output logic       empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    decode_data         mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               push_ok;
    logic               pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally at DEPTH (power of two); flush squashes everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: unoccupied entries are never presented downstream.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/dispatch_ctrl.sv
// Dispatch controller: buffers decode packets and steers the head packet to the
// ALU, MEM or BR issue queue; malformed heads are dropped with illegal=1.
// Ports: clk/reset, flush, decode handshake (dec_valid/dec_ready/dec_data),
//        disp_data shared by all queues, per-queue valid/ready pairs, illegal,
//        saturating stall_cnt of cycles a legal head waited on its queue.
module dispatch_ctrl
    import types_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned STALL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               dec_valid,
    output logic               dec_ready,
    input  decode_data         dec_data,
    output decode_data         disp_data,
    output logic               alu_valid,
    input  logic               alu_ready,
    output logic               mem_valid,
    input  logic               mem_ready,
    output logic               br_valid,
    input  logic               br_ready,
    output logic               illegal,
    output logic [STALL_W-1:0] stall_cnt
);

    decode_data head;
    fu_sel_e    sel;
    logic       full;
    logic       empty;
    logic       push;
    logic       pop;
    logic       head_vld;
    logic       stall;

    // Ready depends only on buffered state and flush, never on downstream readies.
    assign dec_ready = !full && !flush;
    assign push      = dec_valid && dec_ready;
    assign disp_data = empty ? '0 : head;

    dispatch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (dec_data),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    // Steering: one-hot flags pick a queue, anything else is dropped as illegal.
    always_comb begin
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        br_valid  = 1'b0;
        illegal   = 1'b0;
        stall     = 1'b0;
        head_vld  = !empty && !flush;
        sel       = fu_sel(head);
        if (head_vld) begin
            case (sel)
                FU_ALU: begin
                    alu_valid = 1'b1;
                    stall     = !alu_ready;
                end
                FU_MEM: begin
                    mem_valid = 1'b1;
                    stall     = !mem_ready;
                end
                FU_BR: begin
                    br_valid = 1'b1;
                    stall    = !br_ready;
                end
                default: illegal = 1'b1;
            endcase
        end
    end

    assign pop = illegal
              || (alu_valid && alu_ready)
              || (mem_valid && mem_ready)
              || (br_valid  && br_ready);

    // Saturating stall counter; survives flush, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {STALL_W{1'b1}})) begin
            stall_cnt <= stall_cnt + STALL_W'(1);
        end
    end

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Self-checking bench for dispatch_ctrl: directed scenarios plus a randomized
// stream checked against a queue-based reference model.
module tb_dispatch_ctrl;
    import types_pkg::*;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned STALL_W = 4;
    localparam int          SAT     = (1 << STALL_W) - 1;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               flush = 1'b0;
    logic               dec_valid = 1'b0;
    logic               dec_ready;
    decode_data         dec_data = '0;
    decode_data         disp_data;
    logic               alu_valid, mem_valid, br_valid, illegal;
    logic               alu_ready = 1'b1, mem_ready = 1'b1, br_ready = 1'b1;
    logic [STALL_W-1:0] stall_cnt;

    dispatch_ctrl #(.DEPTH(DEPTH), .STALL_W(STALL_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .dec_valid (dec_valid),
        .dec_ready (dec_ready),
        .dec_data  (dec_data),
        .disp_data (disp_data),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .br_valid  (br_valid),
        .br_ready  (br_ready),
        .illegal   (illegal),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic               ready;
        logic               alu;
        logic               mem;
        logic               br;
        logic               ill;
        decode_data         disp;
        logic [STALL_W-1:0] stall;
    } exp_t;

    int         n_vec = 0;
    int         n_err = 0;
    decode_data q[$];
    int         m_stall = 0;

    function automatic decode_data mk(input logic [2:0] fu, input logic [31:0] pc);
        decode_data d;
        d.pc     = pc;
        d.opcode = 8'(pc);
        {d.fu_alu, d.fu_mem, d.fu_br} = fu;
        return d;
    endfunction

    // Reference: a list of buffered packets; the head goes to the single flagged unit.
    function automatic exp_t model_exp();
        exp_t       e;
        decode_data h;
        int         nflags;
        e       = '0;
        e.ready = (q.size() != DEPTH) && !flush;
        e.stall = STALL_W'(m_stall);
        if (q.size() != 0) begin
            h      = q[0];
            e.disp = h;
            nflags = int'(h.fu_alu) + int'(h.fu_mem) + int'(h.fu_br);
            if (!flush) begin
                if (nflags != 1) e.ill = 1'b1;
                else begin
                    e.alu = h.fu_alu;
                    e.mem = h.fu_mem;
                    e.br  = h.fu_br;
                end
            end
        end
        return e;
    endfunction

    function automatic exp_t observe();
        exp_t o;
        o.ready = dec_ready;
        o.alu   = alu_valid;
        o.mem   = mem_valid;
        o.br    = br_valid;
        o.ill   = illegal;
        o.disp  = disp_data;
        o.stall = stall_cnt;
        return o;
    endfunction

    always @(posedge clk or posedge reset) begin
        exp_t e;
        if (reset) begin
            q.delete();
            m_stall = 0;
        end else begin
            e = model_exp();
            if ((e.alu && !alu_ready) || (e.mem && !mem_ready) || (e.br && !br_ready))
                if (m_stall < SAT) m_stall++;
            if (flush) q.delete();
            else begin
                if (e.ill || (e.alu && alu_ready) || (e.mem && mem_ready) || (e.br && br_ready))
                    void'(q.pop_front());
                if (dec_valid && e.ready) q.push_back(dec_data);
            end
        end
    end

    task automatic do_reset();
        reset     = 1'b1;
        flush     = 1'b0;
        dec_valid = 1'b0;
        dec_data  = '0;
        alu_ready = 1'b1;
        mem_ready = 1'b1;
        br_ready  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        exp_t o, x;
        do_reset();
        reset = 1'b1;
        #1;
        x = '0;
        x.ready = 1'b1;
        o = observe();
        n_vec++;
        if (o !== x) begin n_err++; $display("FAIL reset_held: got %h want %h", o, x); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        o = observe();
        n_vec++;
        if (o !== x) begin n_err++; $display("FAIL reset_released: got %h want %h", o, x); end
    endtask

    task automatic test_alu_single();
        do_reset();
        dec_valid = 1'b1;
        dec_data  = mk(3'b100, 32'h100);
        @(negedge clk);
        dec_valid = 1'b0;
        n_vec++;
        if ({dec_ready, alu_valid, mem_valid, br_valid, illegal, disp_data.pc} !== {5'b11000, 32'h100}) begin
            n_err++;
            $display("FAIL alu_single_head: got %b pc=%h want 11000 pc=100",
                     {dec_ready, alu_valid, mem_valid, br_valid, illegal}, disp_data.pc);
        end
        @(negedge clk);
        n_vec++;
        if ({dec_ready, alu_valid, mem_valid, br_valid, illegal, disp_data} !== {5'b10000, 43'd0}) begin
            n_err++;
            $display("FAIL alu_single_empty: got %b disp=%h want 10000 disp=0",
                     {dec_ready, alu_valid, mem_valid, br_valid, illegal}, disp_data);
        end
    endtask

    task automatic test_full_stall();
        do_reset();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dec_valid = 1'b1;
            dec_data  = mk(3'b010, 32'h200 + 32'(i));
            @(negedge clk);
        end
        dec_data = mk(3'b010, 32'h204);
        n_vec++;
        if ({dec_ready, mem_valid, disp_data.pc, stall_cnt} !== {2'b01, 32'h200, 4'd3}) begin
            n_err++;
            $display("FAIL full_after_4: got rdy=%b mv=%b pc=%h st=%0d want rdy=0 mv=1 pc=200 st=3",
                     dec_ready, mem_valid, disp_data.pc, stall_cnt);
        end
        @(negedge clk);
        @(negedge clk);
        mem_ready = 1'b1;
        n_vec++;
        if ({dec_ready, mem_valid, disp_data.pc, stall_cnt} !== {2'b01, 32'h200, 4'd5}) begin
            n_err++;
            $display("FAIL fifth_held: got rdy=%b mv=%b pc=%h st=%0d want rdy=0 mv=1 pc=200 st=5",
                     dec_ready, mem_valid, disp_data.pc, stall_cnt);
        end
        @(negedge clk);
        n_vec++;
        if ({dec_ready, mem_valid, disp_data.pc} !== {2'b11, 32'h201}) begin
            n_err++;
            $display("FAIL ready_after_pop: got rdy=%b mv=%b pc=%h want rdy=1 mv=1 pc=201",
                     dec_ready, mem_valid, disp_data.pc);
        end
        @(negedge clk);
        dec_valid = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            n_vec++;
            if ({mem_valid, disp_data.pc} !== {1'b1, 32'h200 + 32'(i)}) begin
                n_err++;
                $display("FAIL drain_order_%0d: got mv=%b pc=%h want mv=1 pc=%h",
                         i, mem_valid, disp_data.pc, 32'h200 + 32'(i));
            end
            @(negedge clk);
        end
        n_vec++;
        if ({dec_ready, mem_valid, stall_cnt} !== {2'b10, 4'd5}) begin
            n_err++;
            $display("FAIL drain_done: got rdy=%b mv=%b st=%0d want rdy=1 mv=0 st=5",
                     dec_ready, mem_valid, stall_cnt);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        dec_valid = 1'b1;
        dec_data  = mk(3'b101, 32'h300);
        @(negedge clk);
        dec_data = mk(3'b001, 32'h208);
        n_vec++;
        if ({alu_valid, mem_valid, br_valid, illegal} !== 4'b0001) begin
            n_err++;
            $display("FAIL illegal_drop: got %b want 0001", {alu_valid, mem_valid, br_valid, illegal});
        end
        @(negedge clk);
        dec_valid = 1'b0;
        n_vec++;
        if ({alu_valid, mem_valid, br_valid, illegal, disp_data.pc} !== {4'b0010, 32'h208}) begin
            n_err++;
            $display("FAIL br_after_illegal: got %b pc=%h want 0010 pc=208",
                     {alu_valid, mem_valid, br_valid, illegal}, disp_data.pc);
        end
        @(negedge clk);
        n_vec++;
        if ({alu_valid, mem_valid, br_valid, illegal} !== 4'b0000) begin
            n_err++;
            $display("FAIL illegal_idle: got %b want 0000", {alu_valid, mem_valid, br_valid, illegal});
        end
    endtask

    task automatic test_flush();
        do_reset();
        alu_ready = 1'b0;
        mem_ready = 1'b0;
        br_ready  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dec_valid = 1'b1;
            dec_data  = mk(3'b100, 32'h400 + 32'(i));
            @(negedge clk);
        end
        dec_data = mk(3'b100, 32'h4FF);
        flush    = 1'b1;
        #1;
        n_vec++;
        if ({dec_ready, alu_valid, mem_valid, br_valid, illegal} !== 5'b00000) begin
            n_err++;
            $display("FAIL flush_cycle: got %b want 00000",
                     {dec_ready, alu_valid, mem_valid, br_valid, illegal});
        end
        @(negedge clk);
        flush     = 1'b0;
        dec_valid = 1'b0;
        #1;
        n_vec++;
        if ({dec_ready, alu_valid, mem_valid, br_valid, illegal, disp_data, stall_cnt}
                !== {5'b10000, 43'd0, 4'd2}) begin
            n_err++;
            $display("FAIL after_flush: got %b disp=%h st=%0d want 10000 disp=0 st=2",
                     {dec_ready, alu_valid, mem_valid, br_valid, illegal}, disp_data, stall_cnt);
        end
        alu_ready = 1'b1;
        mem_ready = 1'b1;
        br_ready  = 1'b1;
        dec_valid = 1'b1;
        dec_data  = mk(3'b001, 32'h500);
        @(negedge clk);
        dec_valid = 1'b0;
        n_vec++;
        if ({alu_valid, br_valid, disp_data.pc} !== {2'b01, 32'h500}) begin
            n_err++;
            $display("FAIL post_flush_head: got av=%b bv=%b pc=%h want av=0 bv=1 pc=500",
                     alu_valid, br_valid, disp_data.pc);
        end
        @(negedge clk);
    endtask

    task automatic test_stream(input int round);
        int          sent;
        int          total;
        logic [31:0] sb[$];
        logic [31:0] want_pc;
        logic        prev_pend;
        logic [2:0]  prev_v;
        decode_data  prev_d;
        exp_t        e, o;
        logic [2:0]  kind;
        logic        fire;
        sent      = 0;
        total     = 2 * DEPTH + 1;
        prev_pend = 1'b0;
        prev_v    = '0;
        prev_d    = '0;
        do_reset();
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (sent == total && q.size() == 0) break;
            alu_ready = 1'($urandom_range(0, 1));
            mem_ready = 1'($urandom_range(0, 1));
            br_ready  = 1'($urandom_range(0, 1));
            case (sent % 3)
                0:       kind = 3'b100;
                1:       kind = 3'b010;
                default: kind = 3'b001;
            endcase
            dec_valid = (sent < total) && ($urandom_range(0, 3) != 0);
            dec_data  = mk(kind, 32'h600 + 32'(round * 16 + sent));
            #1;
            e = model_exp();
            o = observe();
            n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL stream_r%0d_c%0d: got %h want %h", round, cyc, o, e);
            end
            if (prev_pend) begin
                n_vec++;
                if ({alu_valid, mem_valid, br_valid, disp_data} !== {prev_v, prev_d}) begin
                    n_err++;
                    $display("FAIL stream_hold_r%0d_c%0d: got %b %h want %b %h",
                             round, cyc, {alu_valid, mem_valid, br_valid}, disp_data, prev_v, prev_d);
                end
            end
            fire = (alu_valid && alu_ready) || (mem_valid && mem_ready) || (br_valid && br_ready);
            if (fire) begin
                want_pc = (sb.size() != 0) ? sb.pop_front() : 32'hDEAD_BEEF;
                n_vec++;
                if (disp_data.pc !== want_pc) begin
                    n_err++;
                    $display("FAIL stream_order_r%0d_c%0d: got pc=%h want pc=%h",
                             round, cyc, disp_data.pc, want_pc);
                end
            end
            if (dec_valid && e.ready) begin
                sb.push_back(dec_data.pc);
                sent++;
            end
            prev_pend = (alu_valid && !alu_ready) || (mem_valid && !mem_ready) || (br_valid && !br_ready);
            prev_v    = {alu_valid, mem_valid, br_valid};
            prev_d    = disp_data;
            @(negedge clk);
        end
        dec_valid = 1'b0;
        #1;
        n_vec++;
        if ({dec_ready, alu_valid, mem_valid, br_valid, illegal, 1'(sb.size() != 0)} !== 6'b100000) begin
            n_err++;
            $display("FAIL stream_end_r%0d: got %b left=%0d want 10000 left=0",
                     round, {dec_ready, alu_valid, mem_valid, br_valid, illegal}, sb.size());
        end
    endtask

    task automatic test_saturate_reset();
        exp_t o, x;
        do_reset();
        br_ready  = 1'b0;
        dec_valid = 1'b1;
        dec_data  = mk(3'b001, 32'h700);
        @(negedge clk);
        dec_data = mk(3'b010, 32'h701);
        @(negedge clk);
        dec_valid = 1'b0;
        repeat (20) @(negedge clk);
        n_vec++;
        if ({stall_cnt, br_valid, disp_data.pc} !== {4'd15, 1'b1, 32'h700}) begin
            n_err++;
            $display("FAIL stall_sat: got st=%0d bv=%b pc=%h want st=15 bv=1 pc=700",
                     stall_cnt, br_valid, disp_data.pc);
        end
        #2;
        reset = 1'b1;
        #1;
        x = '0;
        x.ready = 1'b1;
        o = observe();
        n_vec++;
        if (o !== x) begin n_err++; $display("FAIL async_reset: got %h want %h", o, x); end
        @(negedge clk);
        reset = 1'b0;
        br_ready = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_alu_single();
        test_full_stall();
        test_illegal();
        test_flush();
        for (int r = 0; r < 3; r++) test_stream(r);
        test_saturate_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
